// File: rtl/classifier_topic_aging_if.sv
// classifier_topic_aging_if
// Bundles the aging block's topic-memory and expire-notification traffic:
//   topic_etime_rd/raddr    -> etime read request (aging block drives)
//   topic_etime_ack/rdata   <- etime read response (memory drives)
//   topic_key_wr/waddr/wdata-> key clear write (aging block drives)
//   expire_valid/tid        -> expired entry notification (aging block drives)
//   expire_ack              <- notification accepted (hash cleanup drives)
// master: the aging block.  slave: the memory / hash-cleanup side.

`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 10
`endif
`ifndef EXP_TIME_NBITS
`define EXP_TIME_NBITS 32
`endif
`ifndef TOPIC_KEY_NBITS
`define TOPIC_KEY_NBITS 32
`endif

interface classifier_topic_aging_if #(
    parameter int VALUE_DEPTH_NBITS = `TOPIC_VALUE_DEPTH_NBITS,
    parameter int ETIME_NBITS       = `EXP_TIME_NBITS,
    parameter int KEY_NBITS         = `TOPIC_KEY_NBITS
);
    logic                         topic_etime_rd;
    logic [VALUE_DEPTH_NBITS-1:0] topic_etime_raddr;
    logic                         topic_etime_ack;
    logic [ETIME_NBITS-1:0]       topic_etime_rdata;
    logic                         topic_key_wr;
    logic [VALUE_DEPTH_NBITS-1:0] topic_key_waddr;
    logic [KEY_NBITS-1:0]         topic_key_wdata;
    logic                         expire_valid;
    logic [VALUE_DEPTH_NBITS-1:0] expire_tid;
    logic                         expire_ack;

    modport master (
        output topic_etime_rd, topic_etime_raddr,
        input  topic_etime_ack, topic_etime_rdata,
        output topic_key_wr, topic_key_waddr, topic_key_wdata,
        output expire_valid, expire_tid,
        input  expire_ack
    );

    modport slave (
        input  topic_etime_rd, topic_etime_raddr,
        output topic_etime_ack, topic_etime_rdata,
        input  topic_key_wr, topic_key_waddr, topic_key_wdata,
        input  expire_valid, expire_tid,
        output expire_ack
    );
endinterface

// File: rtl/classifier_topic_aging.sv
// classifier_topic_aging
// Periodic background sweep of the topic value table. Every entry's
// expiration time is read; entries with a non-zero etime at or before
// current_time get their key cleared and are reported to hash cleanup.
// The sweep yields the topic memories whenever app_busy is high.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   scan_en         sweep enable; dropping it aborts at the next entry boundary
//   scan_interval   idle cycles spent in WAIT before a sweep starts
//   current_time    present time for the expiry compare
//   app_busy        datapath owns the topic memories this cycle
//   mem             topic memory / expire notification bundle (master side)
//   scan_active     high while a sweep is walking entries
//   scan_done       one-cycle pulse when the last entry has been handled
//   expire_count    expirations in the current or last sweep (saturating)
//
// state  | meaning
// IDLE   | reload interval counter, wait for scan_en
// WAIT   | count down scan_interval before starting a sweep
// READ   | issue etime read for addr (held off while app_busy)
// ACK    | wait for etime read data
// CHECK  | compare captured etime against current_time
// EXPIRE | clear key + notify hash cleanup, hold notification until ack
// NEXT   | advance to next entry, finish sweep, or abort on scan_en low

`ifndef TOPIC_VALUE_DEPTH_NBITS
`define TOPIC_VALUE_DEPTH_NBITS 10
`endif
`ifndef EXP_TIME_NBITS
`define EXP_TIME_NBITS 32
`endif
`ifndef TOPIC_KEY_NBITS
`define TOPIC_KEY_NBITS 32
`endif

module classifier_topic_aging #(
    parameter int VALUE_DEPTH_NBITS = `TOPIC_VALUE_DEPTH_NBITS,
    parameter int ETIME_NBITS       = `EXP_TIME_NBITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scan_en,
    input  logic [15:0]              scan_interval,
    input  logic [ETIME_NBITS-1:0]   current_time,
    input  logic                     app_busy,
    classifier_topic_aging_if.master mem,
    output logic                     scan_active,
    output logic                     scan_done,
    output logic [15:0]              expire_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_ACK,
        ST_CHECK,
        ST_EXPIRE,
        ST_NEXT
    } state_t;

    localparam logic [VALUE_DEPTH_NBITS-1:0] ADDR_LAST = '1;

    state_t                       state, state_nxt;
    logic [VALUE_DEPTH_NBITS-1:0] addr;
    logic [15:0]                  wait_cnt;
    logic [ETIME_NBITS-1:0]       etime_q;
    logic                         wr_done;

    logic etime_rd, key_wr, exp_valid, done_pulse;
    logic load_wait, dec_wait, start_sweep, capture, addr_inc, addr_clr;
    logic expired;

    assign expired = (etime_q != '0) && (etime_q <= current_time);

    always_comb begin
        state_nxt   = state;
        etime_rd    = 1'b0;
        key_wr      = 1'b0;
        exp_valid   = 1'b0;
        done_pulse  = 1'b0;
        load_wait   = 1'b0;
        dec_wait    = 1'b0;
        start_sweep = 1'b0;
        capture     = 1'b0;
        addr_inc    = 1'b0;
        addr_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                load_wait = 1'b1;
                if (scan_en) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // WAIT lasts scan_interval cycles, never fewer than one.
                if (!scan_en) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt <= 16'd1) begin
                    start_sweep = 1'b1;
                    state_nxt   = ST_READ;
                end else begin
                    dec_wait = 1'b1;
                end
            end
            ST_READ: begin
                if (!app_busy) begin
                    etime_rd  = 1'b1;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (mem.topic_etime_ack) begin
                    capture   = 1'b1;
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = expired ? ST_EXPIRE : ST_NEXT;
            end
            ST_EXPIRE: begin
                // Key write is a single strobe; the notification stays up
                // from that cycle until hash cleanup accepts it.
                if (!wr_done && !app_busy) begin
                    key_wr    = 1'b1;
                    exp_valid = 1'b1;
                end
                if (wr_done) exp_valid = 1'b1;
                if (exp_valid && mem.expire_ack) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (addr == ADDR_LAST) begin
                    done_pulse = 1'b1;
                    addr_clr   = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (scan_en) begin
                    addr_inc  = 1'b1;
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            addr         <= '0;
            wait_cnt     <= '0;
            etime_q      <= '0;
            wr_done      <= 1'b0;
            expire_count <= '0;
        end else begin
            state   <= state_nxt;
            wr_done <= (state_nxt == ST_EXPIRE) && (wr_done || key_wr);

            if (load_wait)     wait_cnt <= scan_interval;
            else if (dec_wait) wait_cnt <= wait_cnt - 16'd1;

            if (start_sweep || addr_clr) addr <= '0;
            else if (addr_inc)           addr <= addr + 1'b1;

            if (capture) etime_q <= mem.topic_etime_rdata;

            if (start_sweep)
                expire_count <= '0;
            else if (key_wr && (expire_count != 16'hFFFF))
                expire_count <= expire_count + 16'd1;
        end
    end

    assign mem.topic_etime_rd    = etime_rd;
    assign mem.topic_etime_raddr = addr;
    assign mem.topic_key_wr      = key_wr;
    assign mem.topic_key_waddr   = addr;
    assign mem.topic_key_wdata   = '0;
    assign mem.expire_valid      = exp_valid;
    assign mem.expire_tid        = addr;

    assign scan_active = (state != ST_IDLE) && (state != ST_WAIT);
    assign scan_done   = done_pulse;

endmodule

// File: tb/tb_classifier_topic_aging.sv
`ifndef TOPIC_KEY_NBITS
`define TOPIC_KEY_NBITS 32
`endif

module tb_classifier_topic_aging;
    localparam int VD = 2;
    localparam int ET = 8;

    logic        clk;
    logic        rst_n;
    logic        scan_en;
    logic [15:0] scan_interval;
    logic [7:0]  current_time;
    logic        app_busy;
    logic        scan_active;
    logic        scan_done;
    logic [15:0] expire_count;

    classifier_topic_aging_if #(.VALUE_DEPTH_NBITS(VD), .ETIME_NBITS(ET),
                                .KEY_NBITS(`TOPIC_KEY_NBITS)) mem ();

    classifier_topic_aging #(.VALUE_DEPTH_NBITS(VD), .ETIME_NBITS(ET)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en),
        .scan_interval(scan_interval),
        .current_time (current_time),
        .app_busy     (app_busy),
        .mem          (mem),
        .scan_active  (scan_active),
        .scan_done    (scan_done),
        .expire_count (expire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] etime_mem [4];
    int ack_delay = 0;
    int exp_delay = 0;

    // monitor logs
    logic [1:0] rd_q [$];
    int         rd_cyc [$];
    logic [1:0] wr_q [$];
    logic [1:0] exp_q [$];
    int         ack_cyc [$];
    int         vlen_q [$];
    int         done_cnt = 0;
    int         viol = 0;
    int         cyc = 0;
    int         ack_cnt = 0;
    logic [1:0] ack_addr = '0;
    int         vcnt = 0;
    int         vrun = 0;

    // Memory / hash-cleanup responder and protocol monitor, 3 time units
    // after the falling edge so stimulus (falling edge + 1) has settled.
    always @(negedge clk) begin
        #3;
        cyc++;
        if (!rst_n) begin
            ack_cnt = 0; vcnt = 0; vrun = 0;
            mem.topic_etime_ack   = 1'b0;
            mem.topic_etime_rdata = '0;
            mem.expire_ack        = 1'b0;
        end else begin
            if (mem.topic_etime_rd && mem.topic_key_wr) viol++;
            if ((mem.topic_etime_rd || mem.topic_key_wr) && app_busy) viol++;
            if (mem.topic_key_wr && (mem.topic_key_wdata != '0)) viol++;
            if (mem.topic_key_wr && (!mem.expire_valid || mem.expire_tid != mem.topic_key_waddr)) viol++;
            if (mem.topic_etime_rd) begin rd_q.push_back(mem.topic_etime_raddr); rd_cyc.push_back(cyc); end
            if (mem.topic_key_wr) wr_q.push_back(mem.topic_key_waddr);
            if (scan_done) done_cnt++;
            if (mem.expire_valid) vrun++;
            else if (vrun != 0) begin vlen_q.push_back(vrun); vrun = 0; end
            // etime read response after ack_delay extra cycles
            mem.topic_etime_ack = (ack_cnt == 1);
            if (ack_cnt == 1) mem.topic_etime_rdata = etime_mem[ack_addr];
            if (ack_cnt != 0) ack_cnt--;
            if (mem.topic_etime_rd) begin ack_cnt = ack_delay + 1; ack_addr = mem.topic_etime_raddr; end
            // expire acceptance after exp_delay cycles of valid
            if (mem.expire_valid) begin
                mem.expire_ack = (vcnt == exp_delay);
                vcnt++;
            end else begin
                mem.expire_ack = 1'b0;
                vcnt = 0;
            end
            if (mem.expire_valid && mem.expire_ack) begin
                exp_q.push_back(mem.expire_tid);
                ack_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm, input bit rbusy);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (scan_done) begin got = 1'b1; break; end
            if (rbusy && scan_active) app_busy = ($urandom_range(0, 3) == 0);
            tick();
        end
        scan_en  = 1'b0;
        app_busy = 1'b0;
        chk({nm, " scan_done seen"}, int'(got), 1);
        tick();
        tick();
    endtask

    task automatic run_sweep(input logic [15:0] iv, input logic [7:0] ct, input logic [3:0] mask,
                             input int cnt, input bit rbusy, input string nm);
        int rb, wb, eb, db, waits;
        logic [3:0] wm, em;
        bit order_ok;
        rb = rd_q.size(); wb = wr_q.size(); eb = exp_q.size(); db = done_cnt;
        scan_interval = iv; current_time = ct; app_busy = 1'b0; scan_en = 1'b1;
        waits = 0;
        tick();
        while (!scan_active && waits < 100) begin waits++; tick(); end
        wait_done(nm, rbusy);
        chk({nm, " wait cycles"}, waits, (iv == 0) ? 1 : int'(iv));
        chk({nm, " reads"}, rd_q.size() - rb, 4);
        order_ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (rb + i >= rd_q.size() || int'(rd_q[rb+i]) != i) order_ok = 1'b0;
        chk({nm, " read order"}, int'(order_ok), 1);
        wm = '0;
        for (int i = wb; i < wr_q.size(); i++) wm[wr_q[i]] = 1'b1;
        em = '0;
        for (int i = eb; i < exp_q.size(); i++) em[exp_q[i]] = 1'b1;
        chk({nm, " key writes"}, wr_q.size() - wb, cnt);
        chk({nm, " write mask"}, int'(wm), int'(mask));
        chk({nm, " notify mask"}, int'(em), int'(mask));
        chk({nm, " expire_count"}, int'(expire_count), cnt);
        chk({nm, " done pulses"}, done_cnt - db, 1);
    endtask

    typedef struct packed {
        logic [3:0][7:0] et;
        logic [7:0]      ct;
        logic [15:0]     iv;
        logic [3:0]      mask;
        logic [2:0]      cnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int rb, wb, db, vb, ab;
        bit found;
        logic [3:0] mask;
        logic [7:0] ct, e;
        int cnt;

        // et packs as {entry3, entry2, entry1, entry0}
        vecs[0] = '{et: {8'd0, 8'd0,   8'd0, 8'd0},   ct: 8'd0,   iv: 16'd2, mask: 4'b0000, cnt: 3'd0};
        vecs[1] = '{et: {8'd0, 8'd5,   8'd0, 8'd0},   ct: 8'd5,   iv: 16'd1, mask: 4'b0100, cnt: 3'd1};
        vecs[2] = '{et: {8'd0, 8'd6,   8'd0, 8'd0},   ct: 8'd5,   iv: 16'd0, mask: 4'b0000, cnt: 3'd0};
        vecs[3] = '{et: {8'd4, 8'd3,   8'd2, 8'd1},   ct: 8'd3,   iv: 16'd3, mask: 4'b0111, cnt: 3'd3};
        vecs[4] = '{et: {8'd1, 8'd254, 8'd0, 8'd255}, ct: 8'd255, iv: 16'd0, mask: 4'b1101, cnt: 3'd3};
        vecs[5] = '{et: {8'd8, 8'd8,   8'd8, 8'd8},   ct: 8'd7,   iv: 16'd5, mask: 4'b0000, cnt: 3'd0};

        rst_n = 1'b0; scan_en = 1'b0; scan_interval = '0; current_time = '0; app_busy = 1'b0;
        for (int i = 0; i < 4; i++) etime_mem[i] = '0;
        tick(); tick();
        chk("reset outputs", int'({mem.topic_etime_rd, mem.topic_key_wr, mem.expire_valid,
                                   scan_done, scan_active}), 0);
        chk("reset expire_count", int'(expire_count), 0);
        rst_n = 1'b1;
        tick(); tick();

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) etime_mem[i] = vecs[v].et[i];
            run_sweep(vecs[v].iv, vecs[v].ct, vecs[v].mask, int'(vecs[v].cnt), 1'b0,
                      $sformatf("vec%0d", v));
        end

        // app_busy holding off the read, then the key write
        etime_mem[0] = 8'd0; etime_mem[1] = 8'd0; etime_mem[2] = 8'd5; etime_mem[3] = 8'd0;
        rb = rd_q.size(); wb = wr_q.size();
        current_time = 8'd5; scan_interval = 16'd0; app_busy = 1'b1; scan_en = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (scan_active) begin found = 1'b1; break; end
        end
        chk("busy read reached", int'(found), 1);
        repeat (10) tick();
        chk("busy read withheld", rd_q.size() - rb, 0);
        chk("busy read state held", int'(scan_active), 1);
        app_busy = 1'b0;
        tick();
        chk("busy read issued once", rd_q.size() - rb, 1);
        chk("busy read addr", (rd_q.size() > rb) ? int'(rd_q[rb]) : -1, 0);
        found = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (rd_q.size() - rb >= 3) begin found = 1'b1; break; end
            tick();
        end
        chk("busy entry2 read", int'(found), 1);
        app_busy = 1'b1;
        repeat (12) tick();
        chk("busy key_wr withheld", wr_q.size() - wb, 0);
        chk("busy expire_valid low", int'(mem.expire_valid), 0);
        app_busy = 1'b0;
        wait_done("busy", 1'b0);
        chk("busy key_wr once", wr_q.size() - wb, 1);
        chk("busy key_wr addr", (wr_q.size() > wb) ? int'(wr_q[wb]) : -1, 2);
        chk("busy expire_count", int'(expire_count), 1);

        // expire_ack delayed by 3 cycles
        exp_delay = 3;
        vb = vlen_q.size(); ab = ack_cyc.size(); rb = rd_q.size();
        run_sweep(16'd0, 8'd5, 4'b0100, 1, 1'b0, "ackdly");
        chk("ackdly valid cycles", (vlen_q.size() > vb) ? vlen_q[vb] : -1, 4);
        chk("ackdly read3 after ack",
            (rd_q.size() >= rb + 4 && ack_cyc.size() > ab) ? int'(rd_cyc[rb+3] > ack_cyc[ab]) : 0, 1);
        exp_delay = 0;

        // scan_en dropped while waiting for read data of entry 1
        etime_mem[0] = 8'd0; etime_mem[1] = 8'd3; etime_mem[2] = 8'd0; etime_mem[3] = 8'd0;
        ack_delay = 2;
        rb = rd_q.size(); wb = wr_q.size(); db = done_cnt;
        current_time = 8'd5; scan_interval = 16'd0; scan_en = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (rd_q.size() - rb >= 2) begin found = 1'b1; break; end
        end
        chk("abort entry1 read", int'(found), 1);
        scan_en = 1'b0;
        repeat (15) tick();
        chk("abort reads", rd_q.size() - rb, 2);
        chk("abort entry1 cleared", (wr_q.size() == wb + 1) ? int'(wr_q[wb]) : -1, 1);
        chk("abort no done", done_cnt - db, 0);
        chk("abort idle", int'(scan_active), 0);
        chk("abort expire_count", int'(expire_count), 1);
        run_sweep(16'd0, 8'd5, 4'b0010, 1, 1'b0, "restart");
        ack_delay = 0;

        // reset while holding an expire notification
        etime_mem[0] = 8'd0; etime_mem[1] = 8'd0; etime_mem[2] = 8'd5; etime_mem[3] = 8'd0;
        exp_delay = 20;
        current_time = 8'd5; scan_interval = 16'd0; scan_en = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (mem.expire_valid) begin found = 1'b1; break; end
        end
        chk("rst reached expire", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("rst strobes", int'({mem.topic_etime_rd, mem.topic_key_wr, mem.expire_valid,
                                 scan_done, scan_active}), 0);
        chk("rst addresses", int'({mem.topic_etime_raddr, mem.topic_key_waddr, mem.expire_tid}), 0);
        chk("rst expire_count", int'(expire_count), 0);
        scan_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        exp_delay = 0;
        wb = wr_q.size();
        repeat (10) tick();
        chk("rst no key_wr", wr_q.size() - wb, 0);
        chk("rst idle", int'(scan_active), 0);

        // randomized sweeps against the expiry rule
        for (int r = 0; r < 20; r++) begin
            ct = 8'($urandom_range(0, 255));
            mask = '0;
            cnt = 0;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: e = 8'd0;
                    1: e = ct;
                    2: e = (ct == 8'd255) ? 8'd255 : ct + 8'd1;
                    default: e = 8'($urandom_range(0, 255));
                endcase
                etime_mem[i] = e;
                if (e != 0 && e <= ct) begin mask[i] = 1'b1; cnt++; end
            end
            ack_delay = $urandom_range(0, 2);
            exp_delay = $urandom_range(0, 2);
            run_sweep(16'($urandom_range(0, 4)), ct, mask, cnt, 1'b1, $sformatf("rand%0d", r));
        end

        chk("protocol invariants", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
